// File: rtl/lcd_byte_seq.sv
// HD44780 byte sequencer: runs the 4-command init, then sends one application
// byte per enable period, gating the generator's enable onto the panel.
module lcd_byte_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       init_en,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       tx_done,
    output logic       init_done,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    localparam logic [7:0] FUNC_SET   = 8'h38;
    localparam logic [7:0] DISP_CTRL  = 8'h0C;
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] ENTRY_MODE = 8'h06;

    typedef enum logic [1:0] {START, INIT, RUN} state_t;

    state_t      state;
    logic        en_d;
    logic        fe;
    logic        active;
    logic [1:0]  idx;
    logic        hold_valid;
    logic        hold_rs;
    logic [7:0]  hold_data;
    logic        accept;

    assign fe       = en_d & ~en;
    assign wr_ready = (state == RUN) & ~hold_valid;
    assign accept   = wr_valid & wr_ready;
    assign init_en  = 1'b1;
    assign LCD_RW   = 1'b0;
    // active only moves on fe cycles, so the gated enable cannot glitch
    assign LCD_EN   = en & active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= START;
            en_d       <= 1'b1;
            active     <= 1'b0;
            idx        <= '0;
            tx_done    <= 1'b0;
            init_done  <= 1'b0;
            LCD_RS     <= 1'b0;
            LCD_DATA   <= '0;
            hold_valid <= 1'b0;
            hold_rs    <= 1'b0;
            hold_data  <= '0;
        end else begin
            en_d    <= en;
            tx_done <= 1'b0;
            case (state)
                START: begin
                    if (fe) begin
                        LCD_RS   <= 1'b0;
                        LCD_DATA <= FUNC_SET;
                        active   <= 1'b1;
                        idx      <= 2'd1;
                        state    <= INIT;
                    end
                end
                INIT: begin
                    if (fe) begin
                        tx_done <= 1'b1;
                        idx     <= idx + 2'd1;
                        case (idx)
                            2'd1: begin LCD_RS <= 1'b0; LCD_DATA <= DISP_CTRL;  end
                            2'd2: begin LCD_RS <= 1'b0; LCD_DATA <= CLEAR;      end
                            2'd3: begin LCD_RS <= 1'b0; LCD_DATA <= ENTRY_MODE; end
                            default: begin
                                // holding register is always empty on entry to RUN,
                                // so the RUN load rule reduces to releasing the slot
                                init_done <= 1'b1;
                                active    <= 1'b0;
                                state     <= RUN;
                            end
                        endcase
                    end
                end
                RUN: begin
                    if (fe) begin
                        tx_done <= active;
                        if (hold_valid) begin
                            LCD_RS     <= hold_rs;
                            LCD_DATA   <= hold_data;
                            active     <= 1'b1;
                            hold_valid <= 1'b0;
                        end else begin
                            active <= 1'b0;
                        end
                    end
                    if (accept) begin
                        hold_rs    <= wr_rs;
                        hold_data  <= wr_data;
                        hold_valid <= 1'b1;
                    end
                end
                default: state <= START;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_byte_seq.sv
// Directed bench for lcd_byte_seq with a short-period stub enable generator
// (10 cycles high after start, then 20 low / 10 high).
module tb_lcd_byte_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       init_en, wr_ready, tx_done, init_done;
    logic       LCD_EN, LCD_RS, LCD_RW;
    logic [7:0] LCD_DATA;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gen_cnt = 0;
    int tx_cnt = 0;
    int stab_viol = 0;
    int rw_viol = 0;
    logic [8:0] bytes[$];
    int         rise_cyc[$];

    lcd_byte_seq dut (
        .clk(clk), .rst(rst), .en(en), .init_en(init_en),
        .wr_valid(wr_valid), .wr_rs(wr_rs), .wr_data(wr_data),
        .wr_ready(wr_ready), .tx_done(tx_done), .init_done(init_done),
        .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk); #1;
        if (rst) begin
            gen_cnt = 0;
            en = 1'b1;
        end else begin
            gen_cnt++;
            en = (gen_cnt % 30) < 10;
        end
    end

    // records each latched byte at the LCD_EN rise and watches bus stability
    initial begin
        logic       prev_en;
        logic [8:0] prev_bus;
        prev_en = 1'b0;
        prev_bus = '0;
        forever begin
            @(negedge clk);
            if (LCD_EN && !prev_en) begin
                bytes.push_back({LCD_RS, LCD_DATA});
                rise_cyc.push_back(cyc);
            end
            if (LCD_EN && prev_en && ({LCD_RS, LCD_DATA} != prev_bus)) stab_viol++;
            if (LCD_RW !== 1'b0) rw_viol++;
            if (tx_done) tx_cnt++;
            prev_en = LCD_EN;
            prev_bus = {LCD_RS, LCD_DATA};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic wait_tx(input int target);
        for (int i = 0; i < 300; i++) begin
            if (tx_cnt >= target) break;
            tick();
        end
        check("tx_wait", 32'(tx_cnt >= target), 1);
    endtask

    task automatic wait_bytes(input int target);
        for (int i = 0; i < 300; i++) begin
            if (bytes.size() >= target) break;
            tick();
        end
        check("byte_wait", 32'(bytes.size() >= target), 1);
    endtask

    task automatic verify_init(input int base, input int tbase);
        logic [8:0] exp_init[4];
        exp_init = '{9'h038, 9'h00C, 9'h001, 9'h006};
        for (int i = 0; i < 500; i++) begin
            if (init_done) break;
            tick();
        end
        check("init_done", init_done, 1);
        check("tx_at_done", tx_done, 1);
        check("ready_at_done", wr_ready, 1);
        check("init_tx_cnt", tx_cnt - tbase, 4);
        check("init_nbytes", bytes.size() - base, 4);
        if (bytes.size() >= base + 4)
            for (int i = 0; i < 4; i++) check("init_byte", bytes[base + i], exp_init[i]);
    endtask

    task automatic send(input logic rs, input logic [7:0] data);
        wr_valid = 1'b1;
        wr_rs = rs;
        wr_data = data;
        for (int i = 0; i < 100; i++) begin
            if (wr_ready) break;
            tick();
        end
        check("ready_wait", wr_ready, 1);
        tick();
        check("ready_drop", wr_ready, 0);
    endtask

    initial begin
        int b, t, acc;
        logic en_last;

        repeat (3) tick();
        check("rst_init_en", init_en, 1);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_init_done", init_done, 0);
        check("rst_lcd_en", LCD_EN, 0);
        check("rst_lcd_rs", LCD_RS, 0);
        check("rst_lcd_rw", LCD_RW, 0);
        check("rst_lcd_data", LCD_DATA, 8'h00);
        rst = 1'b0;

        verify_init(0, 0);

        // single character, then idle
        b = bytes.size(); t = tx_cnt;
        send(1'b1, 8'h41);
        wr_valid = 1'b0;
        wait_tx(t + 1);
        repeat (90) tick();
        check("single_nbytes", bytes.size() - b, 1);
        if (bytes.size() > b) check("single_byte", bytes[b], 9'h141);
        check("single_tx", tx_cnt - t, 1);

        // back-to-back with valid held high
        b = bytes.size(); t = tx_cnt;
        send(1'b1, 8'h41);
        send(1'b1, 8'h42);
        send(1'b1, 8'h43);
        wr_valid = 1'b0;
        wait_tx(t + 3);
        check("b2b_nbytes", bytes.size() - b, 3);
        if (bytes.size() >= b + 3) begin
            check("b2b_0", bytes[b], 9'h141);
            check("b2b_1", bytes[b + 1], 9'h142);
            check("b2b_2", bytes[b + 2], 9'h143);
            check("b2b_gap1", rise_cyc[b + 1] - rise_cyc[b], 30);
            check("b2b_gap2", rise_cyc[b + 2] - rise_cyc[b + 1], 30);
        end

        // accept in the same cycle as fe: no bypass into the current period
        repeat (40) tick();
        en_last = en;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!en && en_last) break;
            en_last = en;
        end
        check("fe_found", 32'(!en && en_last), 1);
        check("fe_ready", wr_ready, 1);
        b = bytes.size();
        wr_valid = 1'b1; wr_rs = 1'b0; wr_data = 8'h80;
        tick();
        wr_valid = 1'b0;
        acc = cyc;
        wait_bytes(b + 1);
        if (bytes.size() > b) begin
            check("fe_byte", bytes[b], 9'h080);
            check("fe_next_period", 32'((rise_cyc[b] - acc) > 30 && (rise_cyc[b] - acc) < 60), 1);
        end

        // reset while LCD_EN is high during init
        rst = 1'b1; tick(); rst = 1'b0;
        b = bytes.size();
        wait_bytes(b + 2);
        check("pre_rst_en", LCD_EN, 1);
        rst = 1'b1;
        tick();
        check("rst_mid_en", LCD_EN, 0);
        check("rst_mid_done", init_done, 0);
        check("rst_mid_tx", tx_done, 0);
        rst = 1'b0;
        verify_init(bytes.size(), tx_cnt);

        check("bus_stable", stab_viol, 0);
        check("rw_zero", rw_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
